// File: rtl/ysyx_22050854_mdu_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit:
// FSM state encoding and the funct3-style operation codes.
package ysyx_22050854_mdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

endpackage

// File: rtl/ysyx_22050854_mdu_signfix.sv
// Combinational sign handling: 32-bit operand extension, optional two's-complement
// negation (with borrow from the low half when negating the upper product word),
// and optional sign-extension of the low 32 result bits.
module ysyx_22050854_mdu_signfix #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] val_hi,
  input  logic [XLEN-1:0] val_lo,
  input  logic            sel_hi,
  input  logic            sgn_en,
  input  logic            word_in,
  input  logic            neg,
  input  logic            word_out,
  output logic [XLEN-1:0] res
);

  localparam logic [XLEN-1:0] LO32 = XLEN'(32'hFFFF_FFFF);

  logic [XLEN-1:0] sel;
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] inv;
  logic [XLEN-1:0] fixed;

  always_comb begin
    sel   = sel_hi ? val_hi : val_lo;
    ext   = word_in ? ((sel & LO32) | ({XLEN{sgn_en & sel[31]}} & ~LO32)) : sel;
    // The upper half of a negated 2N-bit product only takes the +1 carry when the low half is zero.
    inv   = ~ext + (sel_hi ? XLEN'(val_lo == '0) : XLEN'(1));
    fixed = neg ? inv : ext;
    res   = word_out ? ((fixed & LO32) | ({XLEN{fixed[31]}} & ~LO32)) : fixed;
  end

endmodule

// File: rtl/ysyx_22050854_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring division on
// operand magnitudes, one bit per cycle, with the result held until accepted.
module ysyx_22050854_mdu
  import ysyx_22050854_mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit W_OPS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] LO32    = XLEN'(32'hFFFF_FFFF);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return (v & LO32) | ({XLEN{v[31]}} & ~LO32);
  endfunction

  state_t state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   a_mag, b_mag, result_r;
  logic [2*XLEN-1:0] acc;
  logic              neg_r, hi_r, rem_r, div_r, word_r;

  logic              word_en, accept, s1_en, s2_en, sign1, sign2, mulh;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag1, mag2, dvd_w, spec_res, word_mask, post_lo, post_res;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic              rem_ge;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    word_en   = (W_OPS && (XLEN == 64)) ? is_word : 1'b0;
    accept    = in_valid & in_ready & ~flush;
    s1_en     = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    s2_en     = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sign1     = s1_en & (word_en ? src1[31] : src1[XLEN-1]);
    sign2     = s2_en & (word_en ? src2[31] : src2[XLEN-1]);
    // MULH* in word form is not a legal encoding; it falls back to the MULW low half.
    mulh      = ~op[2] & (op[1:0] != 2'b00) & ~word_en;
    word_mask = word_en ? LO32 : '1;
    div_zero  = op[2] && ((src2 & word_mask) == '0);
    div_ovf   = ((op == OP_DIV) || (op == OP_REM))
                && ((src1 & word_mask) == (word_en ? XLEN'(32'h8000_0000) : MIN_NEG))
                && ((src2 & word_mask) == word_mask);
    special   = div_zero | div_ovf;
    dvd_w     = word_en ? sext32(src1) : src1;
    spec_res  = div_zero ? (op[1] ? dvd_w : '1) : (op[1] ? '0 : dvd_w);
  end

  ysyx_22050854_mdu_signfix #(.XLEN(XLEN)) u_pre1 (
    .val_hi('0), .val_lo(src1), .sel_hi(1'b0), .sgn_en(s1_en), .word_in(word_en),
    .neg(sign1), .word_out(1'b0), .res(mag1)
  );

  ysyx_22050854_mdu_signfix #(.XLEN(XLEN)) u_pre2 (
    .val_hi('0), .val_lo(src2), .sel_hi(1'b0), .sgn_en(s2_en), .word_in(word_en),
    .neg(sign2), .word_out(1'b0), .res(mag2)
  );

  // One iteration; the accumulator doubles as {remainder, quotient} for division.
  always_comb begin
    rem_sh   = {acc[2*XLEN-1:XLEN], a_mag[cnt]};
    rem_diff = rem_sh - {1'b0, b_mag};
    rem_ge   = rem_sh >= {1'b0, b_mag};
    if (div_r) begin
      acc_step = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], rem_ge};
    end else begin
      acc_step = (acc << 1) + (b_mag[cnt] ? {{XLEN{1'b0}}, a_mag} : '0);
    end
    post_lo = rem_r ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
  end

  ysyx_22050854_mdu_signfix #(.XLEN(XLEN)) u_post (
    .val_hi(acc_step[2*XLEN-1:XLEN]), .val_lo(post_lo), .sel_hi(hi_r), .sgn_en(1'b0),
    .word_in(1'b0), .neg(neg_r), .word_out(word_r), .res(post_res)
  );

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (in_valid) state_nxt = special ? S_DONE : S_CALC;
        S_CALC:  if (cnt == '0) state_nxt = S_DONE;
        S_DONE:  if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      result_r <= '0;
      neg_r    <= 1'b0;
      hi_r     <= 1'b0;
      rem_r    <= 1'b0;
      div_r    <= 1'b0;
      word_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_mag  <= mag1;
        b_mag  <= mag2;
        acc    <= '0;
        cnt    <= word_en ? CW'(31) : CW'(XLEN - 1);
        neg_r  <= (op[2] & op[1]) ? sign1 : (sign1 ^ sign2);
        hi_r   <= mulh;
        rem_r  <= op[2] & op[1];
        div_r  <= op[2];
        word_r <= word_en;
        if (special) result_r <= spec_res;
      end else if (state == S_CALC) begin
        acc <= acc_step;
        cnt <= cnt - CW'(1);
        if (cnt == '0) result_r <= post_res;
      end
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign result    = result_r;

endmodule

// File: tb/tb_ysyx_22050854_mdu.sv
// Directed bench for the multiply/divide unit: a vector table of ops with expected
// results and latencies, plus sequences for flush, backpressure and async reset.
module tb_ysyx_22050854_mdu;
  import ysyx_22050854_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic        is_word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        busy;

  ysyx_22050854_mdu #(.XLEN(64), .W_OPS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .is_word(is_word), .src1(src1), .src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b);
    @(negedge clk);
    op = o; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic run_vec(input int i);
    int n;
    issue(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b);
    wait_valid(n);
    chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d latency", i), 64'(n + 1), 64'(vecs[i].lat));
    chk($sformatf("v%0d result", i), result, vecs[i].exp);
    @(posedge clk);
    #1 chk($sformatf("v%0d back to idle", i), 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n;
    logic seen;
    vecs[0]  = '{OP_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{OP_MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{OP_MULH,   1'b0, '1, '1, 64'h0, 65};
    vecs[3]  = '{OP_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[4]  = '{OP_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[5]  = '{OP_DIVU,   1'b1, 64'h1_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 33};
    vecs[6]  = '{OP_DIV,    1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[7]  = '{OP_REMU,   1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[8]  = '{OP_DIV,    1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    vecs[9]  = '{OP_REM,    1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1};
    vecs[10] = '{OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[11] = '{OP_MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[12] = '{OP_DIV,    1'b1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[13] = '{OP_REM,    1'b1, 64'hFFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[14] = '{OP_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 65};
    vecs[15] = '{OP_REMU,   1'b0, 64'd100, 64'd7, 64'd2, 65};
    vecs[16] = '{OP_MULH,   1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[17] = '{OP_DIVU,   1'b1, 64'h8000_0000, 64'h5_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[18] = '{OP_REMU,   1'b1, 64'h8000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Flush in the middle of a division: must abort without producing a result.
    issue(OP_DIVU, 1'b0, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    #1 chk("flush pre busy", 64'(busy), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    chk("flush no late result", 64'(seen), 64'd0);
    run_vec(3);

    // Flush together with in_valid: the op must not be taken.
    @(negedge clk);
    op = OP_DIV; is_word = 1'b0; src1 = 64'd9; src2 = 64'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; flush = 1'b0; end
    chk("flush+valid busy", 64'(busy), 64'd0);
    chk("flush+valid in_ready", 64'(in_ready), 64'd1);

    // Consumer backpressure: result and out_valid must hold.
    out_ready = 1'b0;
    issue(OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_valid(n);
    chk("hold latency", 64'(n + 1), 64'd65);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d out_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d result", c), result, 64'hFFFF_FFFF_FFFF_FFEB);
      chk($sformatf("hold%0d in_ready", c), 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release out_valid", 64'(out_valid), 64'd0);
    chk("release in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset mid-operation.
    issue(OP_DIVU, 1'b0, 64'd100, 64'd7);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd1);
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("post rst out_valid", 64'(out_valid), 64'd0);
    run_vec(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
